rst_sequencer: RTL and testbench

Staged reset controller between the board-level reset synchronizer and the SoC reset domains. It stretches the synchronized reset and releases three domains in a fixed order: bus/memory, then peripherals, then CPU. It also accepts software and watchdog reset requests and records the cause of the most recent reset for a status register.

---
 rtl/rst_sequencer.sv | 109 ++++++++++
 tb/tb_rst_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Staged reset controller: stretches the incoming reset, then releases
// bus, peripheral and CPU domains in order; tracks reset cause and count.
module rst_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sw_rst_req_i,
    input  logic       wdt_rst_req_i,
    output logic       rst_bus_o,
    output logic       rst_periph_o,
    output logic       rst_cpu_o,
    output logic       done_o,
    output logic [1:0] cause_o,
    output logic [7:0] soft_cnt_o
);

    localparam int unsigned MAX_CYCLES =
        (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW =
        (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    typedef enum logic [1:0] {
        HOLD,
        REL_BUS,
        REL_PERIPH,
        RUN
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    cause, cause_n;
    logic [7:0]    soft_cnt, soft_cnt_n;
    logic          req;

    assign req = sw_rst_req_i | wdt_rst_req_i;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CW'(1);
        cause_n    = cause;
        soft_cnt_n = soft_cnt;
        unique case (state)
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    state_n = REL_BUS;
                    cnt_n   = '0;
                end
            end
            REL_BUS: begin
                if (cnt == GAP_LAST) begin
                    state_n = REL_PERIPH;
                    cnt_n   = '0;
                end
            end
            REL_PERIPH: begin
                if (cnt == GAP_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                cnt_n = '0;
                // Requests only count once the CPU is actually running
                if (req) begin
                    state_n = HOLD;
                    cause_n = wdt_rst_req_i ? CAUSE_WDT : CAUSE_SW;
                    if (soft_cnt != 8'hFF) begin
                        soft_cnt_n = soft_cnt + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= HOLD;
            cnt          <= '0;
            cause        <= CAUSE_EXT;
            soft_cnt     <= '0;
            rst_bus_o    <= 1'b1;
            rst_periph_o <= 1'b1;
            rst_cpu_o    <= 1'b1;
            done_o       <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cause        <= cause_n;
            soft_cnt     <= soft_cnt_n;
            // Outputs decoded from the next state so they stay pure flops
            rst_bus_o    <= (state_n == HOLD);
            rst_periph_o <= (state_n == HOLD) || (state_n == REL_BUS);
            rst_cpu_o    <= (state_n != RUN);
            done_o       <= (state_n == RUN);
        end
    end

    assign cause_o    = cause;
    assign soft_cnt_o = soft_cnt;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected output vectors are queued
// from the release schedule and compared one per clock edge.
module tb_rst_sequencer;

    logic       clk;
    logic       rst, sw, wdt;
    logic       rst1;
    logic       bus, periph, cpu, done;
    logic [1:0] cause;
    logic [7:0] soft_cnt;
    logic       bus1, periph1, cpu1, done1;
    logic [1:0] cause1;
    logic [7:0] soft_cnt1;
    logic       zero;

    int         compared;
    int         mismatched;
    int         cyc;
    bit         sel;
    string      tag;
    logic [11:0] expq[$];

    rst_sequencer #(.HOLD_CYCLES(16), .GAP_CYCLES(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_rst_req_i (sw),
        .wdt_rst_req_i(wdt),
        .rst_bus_o    (bus),
        .rst_periph_o (periph),
        .rst_cpu_o    (cpu),
        .done_o       (done),
        .cause_o      (cause),
        .soft_cnt_o   (soft_cnt)
    );

    rst_sequencer #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .clk_i        (clk),
        .rst_i        (rst1),
        .sw_rst_req_i (zero),
        .wdt_rst_req_i(zero),
        .rst_bus_o    (bus1),
        .rst_periph_o (periph1),
        .rst_cpu_o    (cpu1),
        .done_o       (done1),
        .cause_o      (cause1),
        .soft_cnt_o   (soft_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // j = -1 is the edge that sees the reset event; j >= 0 counts from E
    function automatic logic [11:0] exp_vec(int j, int hold, int gap,
                                            logic [1:0] c, logic [7:0] n);
        logic b, p, u;
        b = (j < hold - 1);
        p = (j < hold + gap - 1);
        u = (j < hold + 2 * gap - 1);
        return {b, p, u, ~u, c, n};
    endfunction

    task automatic push_event(logic [1:0] c, logic [7:0] n);
        expq.push_back(exp_vec(-1, 16, 4, c, n));
    endtask

    task automatic push_release(logic [1:0] c, logic [7:0] n,
                                int hold, int gap, int count);
        for (int j = 0; j < count; j++) begin
            expq.push_back(exp_vec(j, hold, gap, c, n));
        end
    endtask

    task automatic step(int n);
        logic [11:0] got, want;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (sel) got = {bus1, periph1, cpu1, done1, cause1, soft_cnt1};
            else     got = {bus, periph, cpu, done, cause, soft_cnt};
            if (expq.size() == 0) begin
                mismatched++;
                $display("FAIL %s cyc %0d: no expectation queued, got %h",
                         tag, cyc, got);
            end else begin
                want = expq.pop_front();
                compared++;
                if (got !== want) begin
                    mismatched++;
                    $display("FAIL %s cyc %0d: got %h expected %h",
                             tag, cyc, got, want);
                end
            end
        end
    endtask

    task automatic sw_event(logic s, logic w, logic [1:0] c, logic [7:0] n);
        sw  = s;
        wdt = w;
        push_event(c, n);
        step(1);
        sw  = 1'b0;
        wdt = 1'b0;
    endtask

    task automatic test_reset();
        tag = "ext_reset";
        rst = 1'b1;
        for (int i = 0; i < 3; i++) push_event(2'b01, 8'd0);
        step(3);
        rst = 1'b0;
        push_release(2'b01, 8'd0, 16, 4, 25);
        step(25);
    endtask

    task automatic test_sw_reset();
        tag = "sw_reset";
        sw_event(1'b1, 1'b0, 2'b10, 8'd1);
        push_release(2'b10, 8'd1, 16, 4, 25);
        step(25);
    endtask

    task automatic test_simultaneous();
        tag = "sw_wdt_same";
        sw_event(1'b1, 1'b1, 2'b11, 8'd2);
        push_release(2'b11, 8'd2, 16, 4, 25);
        step(25);
    endtask

    task automatic test_ignored_req();
        tag = "wdt_in_rel_periph";
        sw_event(1'b1, 1'b0, 2'b10, 8'd3);
        push_release(2'b10, 8'd3, 16, 4, 25);
        step(20);
        wdt = 1'b1;
        step(1);
        wdt = 1'b0;
        step(4);
    endtask

    task automatic test_rst_mid();
        tag = "rst_in_rel_bus";
        sw_event(1'b1, 1'b0, 2'b10, 8'd4);
        push_release(2'b10, 8'd4, 16, 4, 17);
        step(17);
        rst = 1'b1;
        push_event(2'b01, 8'd0);
        step(1);
        rst = 1'b0;
        push_release(2'b01, 8'd0, 16, 4, 25);
        step(25);
    endtask

    task automatic test_saturation();
        logic [7:0] n;
        tag = "saturation";
        for (int k = 1; k <= 300; k++) begin
            n = (k > 255) ? 8'd255 : 8'(k);
            sw_event(1'b1, 1'b0, 2'b10, n);
            push_release(2'b10, n, 16, 4, 25);
            step(25);
        end
    endtask

    task automatic test_rst_priority();
        tag = "rst_with_reqs";
        rst = 1'b1;
        sw  = 1'b1;
        wdt = 1'b1;
        push_event(2'b01, 8'd0);
        step(1);
        rst = 1'b0;
        sw  = 1'b0;
        wdt = 1'b0;
        push_release(2'b01, 8'd0, 16, 4, 25);
        step(25);
    endtask

    task automatic test_hold1_gap1();
        tag = "hold1_gap1";
        sel = 1'b1;
        expq.push_back(exp_vec(-1, 1, 1, 2'b01, 8'd0));
        step(1);
        rst1 = 1'b0;
        push_release(2'b01, 8'd0, 1, 1, 4);
        step(4);
        sel = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        sel        = 1'b0;
        zero       = 1'b0;
        rst        = 1'b1;
        rst1       = 1'b1;
        sw         = 1'b0;
        wdt        = 1'b0;
        test_reset();
        test_sw_reset();
        test_simultaneous();
        test_ignored_req();
        test_rst_mid();
        test_saturation();
        test_rst_priority();
        test_hold1_gap1();
        if (expq.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: %0d expectations unconsumed, 0 required",
                     expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
